// File: rtl/pow5_root_iterative.sv
// pow5_root_iterative: floor fifth root of a 5W-bit value, one result bit per 5 cycles on a shared W x 5W multiplier.
// Optional feature macro POW5_ROOT_EXACT_EN adds out_exact (root^5 == x).
module pow5_root_iterative #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [5*W-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_root,
`ifdef POW5_ROOT_EXACT_EN
   output logic           out_exact,
`endif
   output logic           busy
);
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;
   state_t r_state;
   logic [5*W-1:0] r_x, r_acc;
   logic [W-1:0] r_root, r_cand;
   logic [BW-1:0] r_b;
   logic [1:0] r_cnt;
   logic r_exact;
   logic [6*W-1:0] w_prod;
   logic [5*W-1:0] w_p;
   logic [W-1:0] w_trial;
   logic w_fit;
   assign w_prod = {{W{1'b0}}, r_acc} * {{5*W{1'b0}}, r_cand};
   // cand^k never exceeds 2^(5W)-1, so dropping the top W bits loses nothing
   assign w_p = w_prod[5*W-1:0];
   assign w_fit = w_p <= r_x;
   assign w_trial = r_root | (W'(1) << r_b);
`ifdef POW5_ROOT_EXACT_EN
   assign out_exact = r_exact;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         out_root <= '0;
         busy <= 1'b0;
         r_x <= '0;
         r_acc <= '0;
         r_root <= '0;
         r_cand <= '0;
         r_b <= '0;
         r_cnt <= '0;
         r_exact <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_x <= in_data;
               r_root <= '0;
               r_b <= BW'(W - 1);
               r_exact <= in_data == '0;
               in_ready <= 1'b0;
               busy <= 1'b1;
               r_state <= LOAD;
            end
            LOAD: begin
               r_cand <= w_trial;
               r_acc <= {{4*W{1'b0}}, w_trial};
               r_cnt <= '0;
               r_state <= MUL;
            end
            MUL: begin
               r_acc <= w_p;
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  if (w_fit) r_root <= r_cand;
                  if (w_p == r_x) r_exact <= 1'b1;
                  if (r_b == '0) begin
                     out_root <= w_fit ? r_cand : r_root;
                     out_valid <= 1'b1;
                     busy <= 1'b0;
                     r_state <= DONE;
                  end else begin
                     r_b <= r_b - BW'(1);
                     r_state <= LOAD;
                  end
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pow5_root_iterative.sv
// tb_pow5_root_iterative: scoreboard bench; driver queues expected roots, negedge monitor pops on each output handshake.
module tb_pow5_root_iterative;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [5*W-1:0] in_data = '0;
   logic in_ready, out_valid, busy;
   logic [W-1:0] out_root;
`ifdef POW5_ROOT_EXACT_EN
   logic out_exact;
`endif
   int n_chk = 0, n_fail = 0, n_acc = 0, n_res = 0;
   logic [W:0] exp_q[$];
   bit rand_ready = 1'b0, fixed_ready = 1'b0;

   always #5 clk = ~clk;

   pow5_root_iterative #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
`ifdef POW5_ROOT_EXACT_EN
      .out_exact(out_exact),
`endif
      .busy(busy)
   );

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic longint p5(input longint r);
      return r * r * r * r * r;
   endfunction

   function automatic logic [W:0] model(input longint x);
      longint r = 0;
      for (longint k = 0; k < 256; k++) if (p5(k) <= x) r = k;
      return {p5(r) == x, r[W-1:0]};
   endfunction

   // sole driver of out_ready; runs after the main process has updated its controls
   always @(posedge clk) begin
      #2;
      out_ready = rand_ready ? 1'($urandom_range(1, 0)) : fixed_ready;
   end

   always @(negedge clk) begin : mon
      logic [W:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_result", 1, 0);
         else begin
            e = exp_q.pop_front();
            n_res++;
            check("root", out_root, e[W-1:0]);
`ifdef POW5_ROOT_EXACT_EN
            check("exact", out_exact, e[W]);
`endif
         end
      end
   end

   task automatic send(input longint x, input logic [W:0] e, input bit push);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data = x[5*W-1:0];
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) begin exp_q.push_back(e); n_acc++; end
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 5000 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   longint dx[7] = '{32, 243, 244, 242, 0, 64'd1078203909375, 64'd1099511627775};
   logic [W-1:0] dr[7] = '{8'd2, 8'd3, 8'd3, 8'd2, 8'd0, 8'd255, 8'd255};
   bit de[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int lat;
      logic [W-1:0] held;
      longint x, r;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_root", out_root, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      fixed_ready = 1'b1;
      @(posedge clk);
      #1;
      send(32, {1'b1, 8'd2}, 1'b1);
      check("in_ready_after_accept", in_ready, 0);
      check("busy_after_accept", busy, 1);
      lat = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin lat = k; break; end
      end
      check("latency", lat, 40);
      wait_drain();
      for (int i = 0; i < 7; i++) send(dx[i], {de[i], dr[i]}, 1'b1);
      wait_drain();
      fixed_ready = 1'b0;
      send(243, {1'b1, 8'd3}, 1'b1);
      for (int k = 0; k < 60 && !out_valid; k++) begin @(posedge clk); #1; end
      check("bp_out_valid", out_valid, 1);
      held = out_root;
      for (int k = 0; k < 10; k++) begin
         in_valid = (k == 4);
         in_data = 40'd1;
         @(posedge clk);
         #1;
         check("bp_valid_hold", out_valid, 1);
         check("bp_root_hold", out_root, held);
         check("bp_in_ready_low", in_ready, 0);
      end
      in_valid = 1'b0;
      fixed_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_drop", out_valid, 0);
      check("bp_in_ready_back", in_ready, 1);
      repeat (5) begin @(posedge clk); #1; check("bp_x1_ignored", busy, 0); end
      send(3125, '0, 1'b0);
      repeat (16) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      rst = 1'b0;
      send(3125, {1'b1, 8'd5}, 1'b1);
      wait_drain();
      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         r = longint'($urandom_range(255, 1));
         case (i % 4)
            0: x = {24'd0, 8'($urandom_range(255, 0)), 32'($urandom)};
            1: x = p5(r);
            2: x = p5(r) + longint'($urandom_range(1000, 1));
            default: x = p5(r) - 1;
         endcase
         send(x, model(x), 1'b1);
      end
      wait_drain();
      rand_ready = 1'b0;
      check("result_count", n_res, n_acc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
